sample_capture_buffer: RTL

Triggered single-channel sample capture memory for the three-phase power analyzer. It records a burst of ADC samples into on-chip RAM after an arm command and an optional rising zero-crossing trigger. The Nios II then reads the stored samples back at its own pace. It sits directly downstream of the Nios-controlled 12-bit read-address PIO: that PIO's `out_port` drives `rd_addr`, and `rd_data` feeds a Nios input PIO.

---
 rtl/sample_capture_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/sample_capture_buffer.sv
// rtl/sample_capture_buffer.sv - triggered single-channel sample capture RAM with registered read port
module sample_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [ADDR_W-1:0] cap_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   cap_len_q;
  logic [DATA_W-1:0]   prev;
  logic                prev_ok;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                crossing;
  logic                wr_en;
  logic                last_write;

  // Rising zero crossing: previous sample negative, current one non-negative.
  assign crossing   = prev_ok && prev[DATA_W-1] && !smp_data[DATA_W-1];
  // A write happens for every sample in CAPTURE and for the triggering sample in ARMED.
  assign wr_en      = smp_valid && !abort &&
                      ((state == ST_CAPTURE) || ((state == ST_ARMED) && crossing));
  // The pointer never wraps because the write at cap_len ends the capture.
  assign last_write = (wr_ptr == cap_len_q);

  // Capture control FSM with registered busy/done flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      wr_count  <= '0;
      cap_len_q <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
    end else begin
      if (smp_valid) begin
        prev    <= smp_data;
        prev_ok <= 1'b1;
      end
      if (abort) begin
        // wr_count and RAM are left alone so software can inspect a partial capture.
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        wr_count <= wr_count + 1'b1;
        if (last_write) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= ST_CAPTURE;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
      end else if (arm && ((state == ST_IDLE) || (state == ST_DONE))) begin
        // A sample arriving with arm must not qualify the next one, so prev_ok clear wins.
        cap_len_q <= cap_len;
        wr_ptr    <= '0;
        wr_count  <= '0;
        prev_ok   <= 1'b0;
        busy      <= 1'b1;
        done      <= 1'b0;
        state     <= trig_mode ? ST_ARMED : ST_CAPTURE;
      end
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= smp_data;
    end
  end

  // Registered read port; a same-address write in this cycle returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
